// File: rtl/slice_rmw_pkg.sv
// Shared types and helpers for the slice read-modify-write controller.
// The optional address range check is enabled with SLICE_RMW_ERR_EN.
package slice_rmw_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    bit [31:0] hi;
    bit [31:0] lo;
  } packed_word_t;

  typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, RESP} state_t;

  // Replace one 16-bit lane of a word, leaving the other lanes untouched.
  function automatic packed_word_t set_lane(packed_word_t word, logic [1:0] lane,
                                            logic [LANE_W-1:0] data);
    logic [NUM_LANES*LANE_W-1:0] flat;
    flat = word;
    flat[lane*LANE_W +: LANE_W] = data;
    return packed_word_t'(flat);
  endfunction

endpackage

// File: rtl/slice_rmw_controller_if.sv
// Request/response bus between the two slice clients and the RMW controller.
// rsp_err exists only when SLICE_RMW_ERR_EN is defined.
interface slice_rmw_controller_if #(
  parameter int AW = 3
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [3:0]      req_lane;
  logic [31:0]     req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [63:0]     rsp_data;
  logic            busy;
`ifdef SLICE_RMW_ERR_EN
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_lane, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_lane, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, rsp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_lane, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_lane, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
`endif
endinterface

// File: rtl/slice_rmw_arbiter.sv
// Two-way round-robin arbiter; the pointer flips to the other index on every accept.
module slice_rmw_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic rr_q, rr_d;

  // Contention follows the pointer; a lone requester wins regardless of it.
  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = rr_q;
    end else if (req_i[1]) begin
      gnt_idx_o = 1'b1;
    end
    rr_d = advance_i ? ~rr_q : rr_q;
  end

  assign gnt_o = (req_i == 2'b00) ? 2'b00 : (gnt_idx_o ? 2'b10 : 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/slice_rmw_controller.sv
// Shared 64-bit word bank with per-lane read-modify-write for two requesters.
// Define SLICE_RMW_ERR_EN to flag out-of-range addresses instead of wrapping them.
module slice_rmw_controller
  import slice_rmw_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [63:0] INIT_WORD = 64'hFEDC_BA98_7654_3210
) (
  input logic                   clk,
  input logic                   rst_n,
  slice_rmw_controller_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t       state_q, state_d;
  logic [1:0]   gnt;
  logic         gnt_idx;
  logic         accept;
  logic         id_q, id_d;
  logic         write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]   lane_q, lane_d;
  logic [15:0]  wdata_q, wdata_d;
  logic         err_q, err_d;
  packed_word_t rd_q, rd_d;
  packed_word_t rsp_data_q, rsp_data_d;
  logic         bank_we;
  logic [AW-1:0] sel_addr;
  logic [1:0]   sel_lane;
  logic [15:0]  sel_data;
  logic         sel_err;
  packed_word_t bank_q [DEPTH];

  slice_rmw_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid),
    .advance_i (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign bus.req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);

  assign sel_addr = gnt_idx ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  assign sel_lane = gnt_idx ? bus.req_lane[3:2]       : bus.req_lane[1:0];
  assign sel_data = gnt_idx ? bus.req_data[31:16]     : bus.req_data[15:0];

`ifdef SLICE_RMW_ERR_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign sel_err = ({1'b0, sel_addr} >= DEPTH_W);
`else
  assign sel_err = 1'b0;
`endif

  // One operation in flight: capture on accept, read, patch, optionally write back, respond.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    write_d    = write_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    bank_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          id_d    = gnt_idx;
          write_d = bus.req_write[gnt_idx];
          addr_d  = sel_addr;
          lane_d  = sel_lane;
          wdata_d = sel_data;
          err_d   = sel_err;
        end
      end
      READ: begin
        rd_d    = bank_q[addr_q];
        state_d = MODIFY;
      end
      MODIFY: begin
        if (err_q) begin
          rsp_data_d = '0;
        end else if (write_q) begin
          rsp_data_d = set_lane(rd_q, lane_q, wdata_q);
        end else begin
          rsp_data_d = rd_q;
        end
        state_d = (write_q && !err_q) ? WRITE : RESP;
      end
      WRITE: begin
        bank_we = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Reset restores every word, so an aborted write leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= packed_word_t'(INIT_WORD);
      end
    end else if (bank_we) begin
      bank_q[addr_q] <= rsp_data_q;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef SLICE_RMW_ERR_EN
  assign bus.rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_slice_rmw_controller.sv
// Self-checking bench for slice_rmw_controller: directed table, corner sequences, random ops.
// With SLICE_RMW_ERR_EN defined it runs on a 6-word bank and exercises the range check.
module tb_slice_rmw_controller;

`ifdef SLICE_RMW_ERR_EN
  localparam int DEPTH = 6;
`else
  localparam int DEPTH = 8;
`endif
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] INIT = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slice_rmw_controller_if #(.AW(AW)) bus ();

  slice_rmw_controller #(.DEPTH(DEPTH), .INIT_WORD(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents and the round-robin pointer.
  logic [63:0] mdl [DEPTH];
  bit          rr;

  // Pending request per requester (held until accepted).
  bit          pv [2];
  bit          pw [2];
  logic [AW-1:0] pa [2];
  logic [1:0]  pl [2];
  logic [15:0] pd [2];

  int actGrant;

  typedef struct {
    int          id;
    bit          wr;
    int          addr;
    int          lane;
    logic [15:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t tab [9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i]          = pv[i];
      bus.req_write[i]          = pw[i];
      bus.req_addr[i*AW +: AW]  = pa[i];
      bus.req_lane[i*2 +: 2]    = pl[i];
      bus.req_data[i*16 +: 16]  = pd[i];
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
    rr = 1'b0;
  endtask

  task automatic doReset();
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    applyStimulus();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
  endtask

  task automatic setReq(input int i, input bit w, input int a, input int l, input logic [15:0] d);
    pv[i] = 1'b1;
    pw[i] = w;
    pa[i] = AW'(a);
    pl[i] = 2'(l);
    pd[i] = d;
  endtask

  // Drive the pending requests, expect one accept, then follow it to the response.
  task automatic runOp(input int hold, input bit useTab, input logic [63:0] tabExp, input string name);
    int            g;
    int            lat;
    int            expLat;
    logic [1:0]    expRdy;
    logic [63:0]   exp;
    logic [AW-1:0] a;
    bit            expErr;
    applyStimulus();
    #1;
    g      = (pv[0] && pv[1]) ? int'(rr) : (pv[1] ? 1 : 0);
    expRdy = (g == 1) ? 2'b10 : 2'b01;
    actGrant = bus.req_ready[1] ? 1 : 0;
    checkOutput({name, " req_ready"}, 64'(bus.req_ready), 64'(expRdy));
    a      = pa[g];
    expErr = (int'(a) >= DEPTH);
    if (expErr) begin
      exp = '0;
    end else begin
      exp = mdl[a];
      if (pw[g]) exp[pl[g]*16 +: 16] = pd[g];
    end
    if (useTab) exp = tabExp;
    expLat = (pw[g] && !expErr) ? 4 : 3;
    @(posedge clk);
    #1;
    pv[g] = 1'b0;
    applyStimulus();
    rr = ~rr;
    lat = 1;
    checkOutput({name, " busy"}, 64'(bus.busy), 64'(1));
    while (!bus.rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, " rsp_data"}, bus.rsp_data, exp);
    checkOutput({name, " rsp_id"}, 64'(bus.rsp_id), 64'(g));
`ifdef SLICE_RMW_ERR_EN
    checkOutput({name, " rsp_err"}, 64'(bus.rsp_err), 64'(expErr));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput({name, " hold rsp_valid"}, 64'(bus.rsp_valid), 64'(1));
      checkOutput({name, " hold rsp_data"}, bus.rsp_data, exp);
      checkOutput({name, " hold req_ready"}, 64'(bus.req_ready), 64'(0));
      checkOutput({name, " hold busy"}, 64'(bus.busy), 64'(1));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checkOutput({name, " done rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    checkOutput({name, " done busy"}, 64'(bus.busy), 64'(0));
    if (pw[g] && !expErr) mdl[a][pl[g]*16 +: 16] = pd[g];
  endtask

  initial begin
    tab[0] = '{0, 1'b0, 0, 0, 16'h0000, INIT};
    tab[1] = '{1, 1'b1, 1, 2, 16'hAAAA, 64'hFEDC_AAAA_7654_3210};
    tab[2] = '{0, 1'b0, 1, 0, 16'h0000, 64'hFEDC_AAAA_7654_3210};
    tab[3] = '{1, 1'b0, 0, 0, 16'h0000, INIT};
    tab[4] = '{0, 1'b1, 2, 0, 16'h1111, 64'hFEDC_BA98_7654_1111};
    tab[5] = '{1, 1'b1, 2, 3, 16'h2222, 64'h2222_BA98_7654_1111};
    tab[6] = '{0, 1'b1, 2, 1, 16'h3333, 64'h2222_BA98_3333_1111};
    tab[7] = '{1, 1'b1, 2, 2, 16'h4444, 64'h2222_4444_3333_1111};
    tab[8] = '{0, 1'b0, 2, 0, 16'h0000, 64'h2222_4444_3333_1111};

    rst_n = 1'b1;
    #2;
    doReset();

    // Reset state
    #1;
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("reset rsp_id", 64'(bus.rsp_id), 64'(0));
    checkOutput("reset rsp_data", bus.rsp_data, 64'(0));
    checkOutput("reset busy", 64'(bus.busy), 64'(0));
`ifdef SLICE_RMW_ERR_EN
    checkOutput("reset rsp_err", 64'(bus.rsp_err), 64'(0));
`endif

    // Directed table: one requester at a time
    for (int i = 0; i < 9; i++) begin
      setReq(tab[i].id, tab[i].wr, tab[i].addr, tab[i].lane, tab[i].data);
      runOp(i % 2, 1'b1, tab[i].exp, $sformatf("table%0d", i));
    end

    // Both requesters valid from reset: grants alternate and all four lanes land
    doReset();
    setReq(0, 1'b1, 4, 0, 16'hA0A0);
    setReq(1, 1'b1, 4, 1, 16'hB1B1);
    runOp(0, 1'b0, '0, "rr op0");
    checkOutput("rr grant0", 64'(actGrant), 64'(0));
    setReq(0, 1'b1, 4, 2, 16'hC2C2);
    runOp(0, 1'b0, '0, "rr op1");
    checkOutput("rr grant1", 64'(actGrant), 64'(1));
    setReq(1, 1'b1, 4, 3, 16'hD3D3);
    runOp(0, 1'b0, '0, "rr op2");
    checkOutput("rr grant2", 64'(actGrant), 64'(0));
    runOp(0, 1'b0, '0, "rr op3");
    checkOutput("rr grant3", 64'(actGrant), 64'(1));
    setReq(0, 1'b0, 4, 0, 16'h0000);
    runOp(0, 1'b1, 64'hD3D3_C2C2_B1B1_A0A0, "rr readback");

    // Response back-pressure for 10 cycles with the other requester waiting
    setReq(0, 1'b0, 2, 0, 16'h0000);
    setReq(1, 1'b1, 3, 1, 16'h5A5A);
    runOp(10, 1'b0, '0, "stall");
    runOp(0, 1'b0, '0, "stall next");

    // Reset asserted during WRITE aborts the op
    doReset();
    setReq(0, 1'b1, 3, 0, 16'h1234);
    applyStimulus();
    @(posedge clk);
    #1;
    pv[0] = 1'b0;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort busy before reset", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy in reset", 64'(bus.busy), 64'(0));
    checkOutput("abort rsp_valid in reset", 64'(bus.rsp_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort no response", 64'(bus.rsp_valid), 64'(0));
    end
    setReq(1, 1'b0, 3, 0, 16'h0000);
    runOp(0, 1'b1, INIT, "abort readback");

`ifdef SLICE_RMW_ERR_EN
    // Out-of-range write is rejected and leaves the bank untouched
    doReset();
    setReq(0, 1'b1, 7, 1, 16'hBEEF);
    runOp(0, 1'b0, '0, "err write");
    for (int k = 0; k < DEPTH; k++) begin
      setReq(1, 1'b0, k, 0, 16'h0000);
      runOp(0, 1'b1, INIT, $sformatf("err intact%0d", k));
    end
`endif

    // Random traffic against the model
    doReset();
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 3) != 0) begin
          setReq(i, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << AW) - 1),
                 $urandom_range(0, 3), 16'($urandom));
        end
      end
      if (!pv[0] && !pv[1]) begin
        setReq(n % 2, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << AW) - 1),
               $urandom_range(0, 3), 16'($urandom));
      end
      runOp($urandom_range(0, 2), 1'b0, '0, $sformatf("rand%0d", n));
    end

    // Final sweep of the whole bank
    pv[1] = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      setReq(0, 1'b0, k, 0, 16'h0000);
      runOp(0, 1'b0, '0, $sformatf("sweep%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
